// File: rtl/riscv_dmem_responder_pkg.sv
// Shared configuration for the data-memory responder: widths and FSM encoding.
package riscv_dmem_responder_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned DMEM_ADDR_BIT    = 10;
  localparam int unsigned NUM_LANES        = XLEN / 8;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned DEF_WAIT_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/riscv_dmem_bank.sv
// Word-organised data storage with byte-lane write enables and a registered read port.
module riscv_dmem_bank
  import riscv_dmem_responder_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [DMEM_ADDR_BIT-1:0] i_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  input  logic [NUM_LANES-1:0]     i_byte_sel,
  output logic [XLEN-1:0]          o_rd_data
);

  localparam int unsigned DEPTH = 2 ** DMEM_ADDR_BIT;

  logic [XLEN-1:0] mem_q [DEPTH];

  // Byte-lane writes and read-data capture; storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < NUM_LANES; b++) begin
        if (i_byte_sel[b]) begin
          mem_q[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      o_rd_data <= mem_q[i_addr];
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Stalling data-memory responder: one request at a time, programmable wait states,
// range-checked access to the bank, response held until the requester takes it.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wen,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wr_data,
  input  logic [3:0]      i_req_byte_sel,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rd_data,
  output logic            o_rsp_err
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                 wen_q;
  logic [XLEN-1:2]      addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [NUM_LANES-1:0] bsel_q;

  logic ready_q, ready_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic rd_sel_q, rd_sel_d;

  logic            accept_c;
  logic            addr_err_c;
  logic            bank_we_c;
  logic            bank_re_c;
  logic [XLEN-1:0] bank_rd_data;
  logic            unused_addr_lsb;

  // Byte offset within the word is irrelevant to a word-organised memory.
  assign unused_addr_lsb = ^i_req_addr[1:0];

  // Any set bit above the word index means the address lies outside the storage.
  assign addr_err_c = |addr_q[XLEN-1:DMEM_ADDR_BIT+2];

  // State, counter and registered handshake/response flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Request latch: captured once at accept, used for the rest of the transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bsel_q  <= '0;
    end else if (accept_c) begin
      wen_q   <= i_req_wen;
      addr_q  <= i_req_addr[XLEN-1:2];
      wdata_q <= i_req_wr_data;
      bsel_q  <= i_req_byte_sel;
    end
  end

  // Next-state, bank strobes and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_sel_d  = rd_sel_q;
    accept_c  = 1'b0;
    bank_we_c = 1'b0;
    bank_re_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && ready_q) begin
          accept_c = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (addr_err_c) begin
          err_d    = 1'b1;
          rd_sel_d = 1'b0;
        end else if (wen_q) begin
          bank_we_c = 1'b1;
          rd_sel_d  = 1'b0;
        end else begin
          bank_re_c = 1'b1;
          rd_sel_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d  = ST_IDLE;
          err_d    = 1'b0;
          rd_sel_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
  end

  riscv_dmem_bank u_bank (
    .i_clk      (i_clk),
    .i_we       (bank_we_c),
    .i_re       (bank_re_c),
    .i_addr     (addr_q[DMEM_ADDR_BIT+1:2]),
    .i_wr_data  (wdata_q),
    .i_byte_sel (bsel_q),
    .o_rd_data  (bank_rd_data)
  );

  // Read word only surfaces for an in-range load; stores, errors and idle show zero.
  assign o_rsp_rd_data = rd_sel_q ? bank_rd_data : '0;
  assign o_req_ready   = ready_q;
  assign o_rsp_valid   = valid_q;
  assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: directed table, multi-cycle corner sequences,
// randomized traffic against a word-array reference model.
module tb_riscv_dmem_responder;

  localparam int W0 = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_data;
  logic [3:0]  req_bsel;

  logic        b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_data;
  logic [3:0]  b_req_bsel;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [12];
  logic [31:0] mem_m [16];

  always #5 clk = ~clk;

  riscv_dmem_responder #(.WAIT_CYCLES(W0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wr_data(req_wdata), .i_req_byte_sel(req_bsel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rd_data(rsp_data), .o_rsp_err(rsp_err)
  );

  riscv_dmem_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_wen(b_req_wen),
    .i_req_addr(b_req_addr), .i_req_wr_data(b_req_wdata), .i_req_byte_sel(b_req_bsel),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_rd_data(b_rsp_data), .o_rsp_err(b_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; called at posedge+1.
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] bsel, input int hold,
                     input logic [31:0] exp_d, input logic exp_e);
    int n;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_bsel = bsel;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      chk({tag, " accept timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble request inputs: the responder must use its latched copy.
    req_valid = 1'b0; req_wen = ~wen; req_addr = $urandom; req_wdata = $urandom;
    req_bsel = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 32'(n), 32'(W0 + 1));
    chk({tag, " data"}, rsp_data, exp_d);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold data"}, rsp_data, exp_d);
      chk({tag, " hold busy"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " clr valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " clr data"}, {rsp_data[30:0], rsp_err}, 32'd0);
    chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        wen, oor;
    logic [3:0]  bsel;
    logic [31:0] addr, d, exp_d;
    int          idx;

    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_bsel = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_wen = 0; b_req_addr = 0; b_req_wdata = 0; b_req_bsel = 0;
    b_rsp_ready = 0;

    // Reset state
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst data", {rsp_data[30:0], rsp_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready", 32'(req_ready), 32'd1);
    chk("post-rst valid", 32'(rsp_valid), 32'd0);

    // Zero-wait-state instance: response one edge after accept
    for (int t = 0; t < 2; t++) begin
      b_req_valid = 1'b1; b_req_wen = (t == 0); b_req_addr = 32'h40;
      b_req_wdata = 32'h600DCAFE; b_req_bsel = 4'hF;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      chk("w0 not early", 32'(b_rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("w0 valid", 32'(b_rsp_valid), 32'd1);
      chk("w0 data", b_rsp_data, (t == 0) ? 32'h0 : 32'h600DCAFE);
      b_rsp_ready = 1'b1;
      @(posedge clk); #1;
      b_rsp_ready = 1'b0;
      chk("w0 clr", 32'(b_rsp_valid), 32'd0);
    end

    // Directed table
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h14,   32'h55555555, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h14,   32'hAAAAAAAA, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h14,   32'h0,        4'hF, 32'h55555555, 1'b0};
    vecs[11] = '{1'b1, 32'h20,   32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    for (int i = 0; i < 12; i++) begin
      txn($sformatf("v%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].bsel,
          0, vecs[i].exp_d, vecs[i].exp_e);
    end

    // Backpressure: response held for 5 cycles, new requests ignored
    txn("bp", 1'b0, 32'h10, 32'h0, 4'hF, 5, 32'hDE22BE44, 1'b0);

    // Reset while a response is pending drops it immediately
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rr valid", 32'(rsp_valid), 32'd1);
    chk("rr data", rsp_data, 32'hDE22BE44);
    #2 rst = 1'b1;
    #1;
    chk("rr drop valid", 32'(rsp_valid), 32'd0);
    chk("rr drop data", {rsp_data[30:0], rsp_err}, 32'd0);
    chk("rr ready low", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rr ready", 32'(req_ready), 32'd1);

    // Reset during WAIT of a store: the store must never land
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    req_bsel = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rw valid", 32'(rsp_valid), 32'd0);
    chk("rw ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    txn("rw load", 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h0BADF00D, 1'b0);

    // Randomized traffic against a word-array model
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = $urandom;
      txn("rinit", 1'b1, 32'h100 + 32'(4 * i), mem_m[i], 4'hF, 0, 32'h0, 1'b0);
    end
    for (int t = 0; t < 40; t++) begin
      wen  = 1'($urandom);
      idx  = int'($urandom % 16);
      oor  = ($urandom % 5) == 0;
      addr = 32'h100 + 32'(4 * idx) + 32'($urandom % 4);
      if (oor) addr = addr | (32'd1 << (12 + ($urandom % 20)));
      d    = $urandom;
      bsel = 4'($urandom);
      if (oor) exp_d = 32'h0;
      else if (wen) begin
        for (int b = 0; b < 4; b++) if (bsel[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        exp_d = 32'h0;
      end else exp_d = mem_m[idx];
      txn($sformatf("r%0d", t), wen, addr, d, bsel, int'($urandom % 4), exp_d, oor);
    end
    // Final readback of every modelled word
    for (int i = 0; i < 16; i++) begin
      txn("rfinal", 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 0, mem_m[i], 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
